// File: rtl/pc_redirect_unit_if.sv
// Bundle of the fetch-PC redirect signals between the pipeline and pc_redirect_unit.
interface pc_redirect_unit_if #(
  parameter int PC_W  = 16,
  parameter int NSRC  = 6,
  parameter int SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1
);
  logic                 stall;
  logic [NSRC-1:0]      redir_valid;
  logic [NSRC*PC_W-1:0] redir_pc;
  logic [PC_W-1:0]      pc_out;
  logic [PC_W-1:0]      pc_seq;
  logic                 flush;
  logic [SRC_W-1:0]     redir_src;
  logic                 pend_valid;
  logic [15:0]          redirect_cnt;

  modport slave (
    input  stall, redir_valid, redir_pc,
    output pc_out, pc_seq, flush, redir_src, pend_valid, redirect_cnt
  );
  modport master (
    output stall, redir_valid, redir_pc,
    input  pc_out, pc_seq, flush, redir_src, pend_valid, redirect_cnt
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch PC generation: fixed-priority redirect arbitration, stall hold with one pending slot,
// registered flush. Optional applied-redirect counter built only with REDIRECT_CNT_EN defined.
module pc_redirect_unit #(
  parameter int              PC_W      = 16,
  parameter int              NSRC      = 6,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              PC_STEP   = 1,
  localparam int             SRC_W     = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input logic              clk,
  input logic              rst_n,
  pc_redirect_unit_if.slave bus
);

  logic [PC_W-1:0]  pc_q, pc_d, pend_pc_q, pend_pc_d, tgt;
  logic [SRC_W-1:0] src_q, src_d, pend_src_q, pend_src_d, win;
  logic             flush_q, flush_d, pend_q, pend_d, any;

  // Later loop iterations overwrite earlier ones, so the highest set index wins.
  always_comb begin
    win = '0;
    any = 1'b0;
    tgt = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.redir_valid[i]) begin
        win = SRC_W'(i);
        any = 1'b1;
        tgt = bus.redir_pc[i*PC_W +: PC_W];
      end
    end
  end

  always_comb begin
    pc_d       = pc_q;
    src_d      = src_q;
    flush_d    = 1'b0;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    pend_src_d = pend_src_q;
    if (!bus.stall) begin
      if (any) begin
        pc_d    = tgt;
        src_d   = win;
        flush_d = 1'b1;
        pend_d  = 1'b0;
      end else if (pend_q) begin
        pc_d    = pend_pc_q;
        src_d   = pend_src_q;
        flush_d = 1'b1;
        pend_d  = 1'b0;
      end else begin
        pc_d = pc_q + PC_W'(PC_STEP);
      end
    end else if (any) begin
      // Equal priority replaces: the younger request from the same source is the live one.
      if (!pend_q || win >= pend_src_q) begin
        pend_pc_d  = tgt;
        pend_src_d = win;
      end
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_VEC;
      src_q      <= '0;
      flush_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      pend_src_q <= '0;
    end else begin
      pc_q       <= pc_d;
      src_q      <= src_d;
      flush_q    <= flush_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      pend_src_q <= pend_src_d;
    end
  end

  assign bus.pc_out     = pc_q;
  assign bus.pc_seq     = pc_q + PC_W'(PC_STEP);
  assign bus.flush      = flush_q;
  assign bus.redir_src  = src_q;
  assign bus.pend_valid = pend_q;

`ifdef REDIRECT_CNT_EN
  logic [15:0] cnt_q;
  logic        applied;

  assign applied = !bus.stall && (any || pend_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt_q <= '0;
    else if (applied && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end

  assign bus.redirect_cnt = cnt_q;
`else
  assign bus.redirect_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Table-driven check of pc_redirect_unit with a queue scoreboard plus async-reset and counter sequences.
module tb_pc_redirect_unit;
  localparam int PC_W = 16;
  localparam int NSRC = 6;

  typedef struct {
    logic        stall;
    logic [5:0]  v;
    logic [95:0] rpc;
    logic [15:0] pc;
    logic        fl;
    logic [2:0]  src;
    logic        pend;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;
  vec_t tv[$];
  vec_t exp_q[$];

  pc_redirect_unit_if #(.PC_W(PC_W), .NSRC(NSRC)) bus ();

  pc_redirect_unit #(.PC_W(PC_W), .NSRC(NSRC), .RESET_VEC(16'h0000), .PC_STEP(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_run++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Unused slots carry junk so a wrong-slice select shows up.
  function automatic logic [95:0] slots(input int i0, input logic [15:0] p0,
                                        input int i1, input logic [15:0] p1);
    logic [95:0] b;
    for (int k = 0; k < NSRC; k++) b[k*16 +: 16] = 16'hBAD0 | 16'(k);
    if (i0 >= 0) b[i0*16 +: 16] = p0;
    if (i1 >= 0) b[i1*16 +: 16] = p1;
    return b;
  endfunction

  task automatic row(input logic st, input logic [5:0] v, input logic [95:0] rpc,
                     input logic [15:0] pc, input logic fl, input logic [2:0] src, input logic pend);
    vec_t t;
    t.stall = st; t.v = v; t.rpc = rpc; t.pc = pc; t.fl = fl; t.src = src; t.pend = pend;
    tv.push_back(t);
  endtask

  task automatic drive_idle();
    bus.stall = 1'b0;
    bus.redir_valid = '0;
    bus.redir_pc = slots(-1, 16'h0, -1, 16'h0);
  endtask

  initial begin
    vec_t e;
    logic [15:0] exp_cnt;
    drive_idle();

    row(0, 6'b000000, slots(-1, 0, -1, 0),               16'h0001, 0, 0, 0);
    row(0, 6'b000000, slots(-1, 0, -1, 0),               16'h0002, 0, 0, 0);
    row(0, 6'b000000, slots(-1, 0, -1, 0),               16'h0003, 0, 0, 0);
    row(0, 6'b010010, slots(1, 16'h0040, 4, 16'h2525),   16'h2525, 1, 4, 0);
    row(0, 6'b000000, slots(-1, 0, -1, 0),               16'h2526, 0, 4, 0);
    row(1, 6'b000010, slots(1, 16'h0100, -1, 0),         16'h2526, 0, 4, 1);
    row(1, 6'b001000, slots(3, 16'h0300, -1, 0),         16'h2526, 0, 4, 1);
    row(1, 6'b000001, slots(0, 16'h0999, -1, 0),         16'h2526, 0, 4, 1);
    row(0, 6'b000000, slots(-1, 0, -1, 0),               16'h0300, 1, 3, 0);
    row(0, 6'b000000, slots(-1, 0, -1, 0),               16'h0301, 0, 3, 0);
    row(0, 6'b100000, slots(5, 16'hFFFE, -1, 0),         16'hFFFE, 1, 5, 0);
    row(0, 6'b000000, slots(-1, 0, -1, 0),               16'hFFFF, 0, 5, 0);
    row(0, 6'b000000, slots(-1, 0, -1, 0),               16'h0000, 0, 5, 0);
    row(1, 6'b000000, slots(-1, 0, -1, 0),               16'h0000, 0, 5, 0);
    row(0, 6'b000001, slots(0, 16'h0010, -1, 0),         16'h0010, 1, 0, 0);
    row(0, 6'b000001, slots(0, 16'h0020, -1, 0),         16'h0020, 1, 0, 0);
    row(1, 6'b000100, slots(2, 16'h0500, -1, 0),         16'h0020, 0, 0, 1);
    row(1, 6'b000000, slots(-1, 0, -1, 0),               16'h0020, 0, 0, 1);
    row(0, 6'b000010, slots(1, 16'h0700, -1, 0),         16'h0700, 1, 1, 0);
    row(0, 6'b000000, slots(-1, 0, -1, 0),               16'h0701, 0, 1, 0);

    // Reset state
    #12;
    chk("rst_pc",   32'(bus.pc_out), 32'h0);
    chk("rst_flush", 32'(bus.flush), 32'h0);
    chk("rst_src",  32'(bus.redir_src), 32'h0);
    chk("rst_pend", 32'(bus.pend_valid), 32'h0);
    chk("rst_cnt",  32'(bus.redirect_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      bus.stall = tv[i].stall;
      bus.redir_valid = tv[i].v;
      bus.redir_pc = tv[i].rpc;
      exp_q.push_back(tv[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("row%0d_pc", i),   32'(bus.pc_out), 32'(e.pc));
      chk($sformatf("row%0d_seq", i),  32'(bus.pc_seq), 32'(16'(e.pc + 16'd1)));
      chk($sformatf("row%0d_flush", i), 32'(bus.flush), 32'(e.fl));
      chk($sformatf("row%0d_src", i),  32'(bus.redir_src), 32'(e.src));
      chk($sformatf("row%0d_pend", i), 32'(bus.pend_valid), 32'(e.pend));
      @(negedge clk);
    end

`ifdef REDIRECT_CNT_EN
    exp_cnt = 16'd6;
`else
    exp_cnt = 16'd0;
`endif
    chk("cnt_after_table", 32'(bus.redirect_cnt), 32'(exp_cnt));

    // Async reset with a pending redirect, asserted between edges
    bus.stall = 1'b1;
    bus.redir_valid = 6'b000100;
    bus.redir_pc = slots(2, 16'h0ABC, -1, 0);
    @(posedge clk); #1;
    chk("pre_rst_pend", 32'(bus.pend_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pc",   32'(bus.pc_out), 32'h0);
    chk("async_pend", 32'(bus.pend_valid), 32'h0);
    chk("async_src",  32'(bus.redir_src), 32'h0);
    chk("async_cnt",  32'(bus.redirect_cnt), 32'h0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_pc",    32'(bus.pc_out), 32'h1);
    chk("post_rst_flush", 32'(bus.flush), 32'h0);
    chk("post_rst_pend",  32'(bus.pend_valid), 32'h0);

`ifdef REDIRECT_CNT_EN
    // Saturation: preload near the top, then apply two redirects
    @(negedge clk);
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    bus.redir_valid = 6'b000001;
    bus.redir_pc = slots(0, 16'h0042, -1, 0);
    @(posedge clk); #1;
    chk("cnt_to_max", 32'(bus.redirect_cnt), 32'hFFFF);
    @(negedge clk);
    @(posedge clk); #1;
    chk("cnt_sat", 32'(bus.redirect_cnt), 32'hFFFF);
    chk("cnt_sat_flush", 32'(bus.flush), 32'h1);
    @(negedge clk);
    drive_idle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
